// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings and responder FSM states
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: four byte lanes, lane i holds byte offset i (big-endian, lane 0 in rdata[31:24])
module mem_byte_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-3:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [2**(ADDR_W-2)];
        always_ff @(posedge clk)
            if (we[i]) mem[idx] <= wdata[31-8*i -: 8];
        assign rdata[31-8*i -: 8] = mem[idx];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: four-phase mov/moc memory responder with fixed latency, big-endian byte/half/word access
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mov,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        moc,
    output logic        err
);
    state_t      state, nxt;
    logic [3:0]  cnt;
    logic        l_rw, l_sext, err_q, bad, fire;
    logic [1:0]  l_size, off;
    logic [31:0] l_addr, l_wdata, wd, word, ext;
    logic [3:0]  we;
    logic [7:0]  b;
    logic [15:0] h;

    assign off  = l_addr[1:0];
    assign bad  = l_size == 2'b11 || (l_size == SZ_HALF && off[0]) ||
                  (l_size == SZ_WORD && off != 2'b00) || |l_addr[31:ADDR_W];
    assign fire = state == BUSY && mov && cnt == 4'd0;
    // reset on the completion edge must still cancel the write
    assign we   = fire && !reset && !l_rw && !bad ?
                  (l_size == SZ_BYTE ? 4'b0001 << off : l_size == SZ_HALF ? 4'b0011 << off : 4'b1111) : 4'b0000;
    assign wd   = l_size == SZ_BYTE ? {4{l_wdata[7:0]}} : l_size == SZ_HALF ? {2{l_wdata[15:0]}} : l_wdata;
    assign b    = word[{~off, 3'b000} +: 8];
    assign h    = word[{~off[1], 4'b0000} +: 16];
    assign ext  = l_size == SZ_BYTE ? {{24{l_sext & b[7]}}, b} :
                  l_size == SZ_HALF ? {{16{l_sext & h[15]}}, h} : word;
    assign moc  = state == DONE;
    assign err  = moc & err_q;

    mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (l_addr[ADDR_W-1:2]),
        .wdata (wd),
        .rdata (word)
    );

    always_comb begin
        nxt = state == IDLE ? (mov ? BUSY : IDLE) :
              state == BUSY ? (!mov ? IDLE : cnt == 4'd0 ? DONE : BUSY) :
              (mov ? DONE : IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
            rdata <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && mov) begin
                l_rw    <= rw;
                l_size  <= size;
                l_sext  <= sign_ext;
                l_addr  <= addr;
                l_wdata <= wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                err_q <= bad;
                if (l_rw && !bad) rdata <= ext;
            end
        end
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the backing store (2**ADDR_W bytes).
REQ-002 Parameter LATENCY, default 2, cycles from MOV sampled to MOC asserted; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 mov  input  1  memory operation valid from initiator; held high until moc seen.
REQ-006 rw  input  1  1 = read, 0 = write; stable while mov high.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 sign_ext  input  1  reads only: 1 sign-extends byte/halfword, 0 zero-extends.
REQ-009 addr  input  32  byte address from MAR; stable while mov high.
REQ-010 wdata  input  32  write data from MDR, right-justified; stable while mov high.
REQ-011 rdata  output  32  read data to MDR, right-justified.
REQ-012 moc  output  1  memory operation complete.
REQ-013 err  output  1  qualifies moc: operation rejected, no storage change.

Function
REQ-014 Four-phase handshake: mov rises -> responder works -> moc rises -> mov falls -> moc falls -> next mov.
REQ-015 FSM states: IDLE, BUSY, DONE.
- IDLE->BUSY when mov=1 at the clock edge; latch rw, size, sign_ext, addr, wdata; load counter with LATENCY-1.
- BUSY: decrement counter each cycle; at counter=0, perform access and go to DONE.
- DONE->IDLE when mov=0.
REQ-016 mov sampled at edge N: moc=1 from edge N+LATENCY; write commits on that same edge.
REQ-017 moc=1 exactly while in DONE; moc goes low on the edge after mov is sampled low.
REQ-018 Byte order is big-endian: the byte at addr is the most significant byte of a word.
REQ-019 Write byte lanes: byte writes wdata[7:0]; halfword writes wdata[15:0] to addr and addr+1; word writes all 4 bytes.
REQ-020 Reads load rdata on the moc-rising edge, extended per size and sign_ext; rdata then holds until the next completed read.
REQ-021 err=1 (with moc) when any of the following holds; no bytes are written and rdata is unchanged:
- size=11;
- halfword access with addr[0]!=0;
- word access with addr[1:0]!=0;
- addr[31:ADDR_W]!=0.
REQ-022 err is valid only while moc=1 and is 0 otherwise.
REQ-023 mov dropped while in BUSY: abort, no write, return to IDLE next edge, moc stays 0.
REQ-024 mov still high in IDLE after a completed cycle cannot occur, because DONE waits for mov=0; no back-to-back access without a low phase.
REQ-025 Input changes while in BUSY or DONE are ignored; the latched values govern the access.

Reset
REQ-026 reset=1 at an edge forces IDLE, moc=0, err=0, rdata=0, counter=0; reset overrides all other events.
REQ-027 Reset during BUSY cancels the pending write; storage array contents are not cleared by reset.

Structure
REQ-028 Shared package mem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-029 Sub-module mem_byte_array holds the storage: synchronous 4-lane byte array with per-lane write enables and a word-aligned combinational read.
REQ-030 The lane-enable and extension logic sits in mem_responder, not in the array.

Verification
REQ-031 Word write 0xDEADBEEF to 0x010, then word read 0x010 -> rdata=0xDEADBEEF, moc rises exactly LATENCY cycles after mov, err=0.
REQ-032 Byte read 0x011 from the same word, sign_ext=1 -> 0xFFFFFFAD; sign_ext=0 -> 0x000000AD.
REQ-033 Halfword write 0x1234 to 0x012, then word read 0x010 -> 0xDEAD1234.
REQ-034 Word write to 0x013 and halfword read at 0x011 -> moc=1, err=1, memory and rdata unchanged; addr=1<<ADDR_W -> err=1.
REQ-035 mov held high 3 cycles past moc -> moc held 3 cycles, falls one cycle after mov falls.
REQ-036 Write 0x55 started, reset or mov drop in BUSY -> moc never rises and a subsequent read returns the old value.
